// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Optional registered leading-zero blanking output enabled by macro BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
    parameter int N = 8,
    parameter int D = 3
) (
    input  logic           sysclk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   bin,
    output logic           ready,
    output logic           done,
`ifdef BIN2BCD_BLANK_EN
    output logic [D-1:0]   blank,
`endif
    output logic [4*D-1:0] bcd
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    sr_q, sr_d;
    logic [4*D-1:0]  work_q, work_d;
    logic [4*D-1:0]  bcd_q, bcd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4*D-1:0]  adj;
    logic [4*D-1:0]  shifted;

    // Add-3 adjust per digit, then shift in the next binary MSB
    always_comb begin
        adj = '0;
        for (int unsigned i = 0; i < D; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            else                          adj[4*i +: 4] = work_q[4*i +: 4];
        end
        shifted = {adj[4*D-2:0], sr_q[N-1]};
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ready   = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    sr_d    = bin;
                    work_d  = '0;
                    cnt_d   = CW'(N);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                work_d = shifted;
                sr_d   = sr_q << 1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    bcd_d   = shifted;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (start) begin
                    sr_d    = bin;
                    work_d  = '0;
                    cnt_d   = CW'(N);
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            work_q  <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            work_q  <= work_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bcd = bcd_q;

`ifdef BIN2BCD_BLANK_EN
    logic [D-1:0] blank_q, blank_d;
    logic         zero_above;

    // Bit i set when digit i and every higher digit of the new result are zero
    always_comb begin
        blank_d    = blank_q;
        zero_above = 1'b1;
        if (state_q == S_SHIFT && cnt_q == CW'(1)) begin
            blank_d = '0;
            for (int unsigned i = D - 1; i > 0; i--) begin
                zero_above = zero_above & (shifted[4*i +: 4] == 4'd0);
                blank_d[i] = zero_above;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) blank_q <= '0;
        else       blank_q <= blank_d;
    end

    assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: driver queues decimal-model results with
// their expected done cycle; a negedge monitor pops and compares on each done.
module tb_bin2bcd_seq;
    localparam int N = 8;
    localparam int D = 3;

    logic           sysclk = 1'b0;
    logic           reset  = 1'b1;
    logic           start  = 1'b0;
    logic [N-1:0]   bin    = '0;
    logic           ready;
    logic           done;
    logic [4*D-1:0] bcd;
`ifdef BIN2BCD_BLANK_EN
    logic [D-1:0]   blank;
`endif

    bin2bcd_seq #(.N(N), .D(D)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .start  (start),
        .bin    (bin),
        .ready  (ready),
        .done   (done),
`ifdef BIN2BCD_BLANK_EN
        .blank  (blank),
`endif
        .bcd    (bcd)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    typedef struct {
        logic [4*D-1:0] exp_bcd;
        logic [D-1:0]   exp_blank;
        int             exp_cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [4*D-1:0] ref_bcd(int v);
        logic [4*D-1:0] r = '0;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [D-1:0] ref_blank(int v);
        logic [D-1:0] r = '0;
        int p = 1;
        for (int i = 1; i < D; i++) begin
            p = p * 10;
            r[i] = (v < p);
        end
        return r;
    endfunction

    // Monitor
    logic           rst_seen;
    logic [4*D-1:0] hold_bcd = '0;
    always @(posedge sysclk) rst_seen <= reset;

    always @(negedge sysclk) begin
        exp_t e;
        if (rst_seen === 1'b1) begin
            check("reset_done", done, 0);
            check("reset_bcd", bcd, 0);
            check("reset_ready", ready, 1);
`ifdef BIN2BCD_BLANK_EN
            check("reset_blank", blank, 0);
`endif
            hold_bcd = '0;
        end else if (done === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                e = q.pop_front();
                check("result_bcd", bcd, e.exp_bcd);
                check("done_cycle", cyc, e.exp_cyc);
`ifdef BIN2BCD_BLANK_EN
                check("result_blank", blank, e.exp_blank);
`endif
                hold_bcd = e.exp_bcd;
            end
        end else begin
            check("hold_bcd", bcd, hold_bcd);
        end
    end

    // Driver
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic issue(int v);
        exp_t e;
        start = 1'b1;
        bin   = N'(v);
        e.exp_bcd   = ref_bcd(v);
        e.exp_blank = ref_blank(v);
        e.exp_cyc   = cyc + N + 1;
        q.push_back(e);
        tick();
        start = 1'b0;
        bin   = N'($urandom);
    endtask

    // Toggles start/bin randomly while busy; those starts must be ignored
    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 4 * N) begin
            start = 1'($urandom_range(0, 1));
            bin   = N'($urandom);
            tick();
            n++;
        end
        start = 1'b0;
        if (!ready) check("ready_timeout", ready, 1);
    endtask

    task automatic convert(int v);
        issue(v);
        wait_ready();
    endtask

    initial begin
        int c;
        int n;

        repeat (3) tick();
        check("init_ready", ready, 1);
        check("init_done", done, 0);
        check("init_bcd", bcd, 0);
        reset = 1'b0;
        tick();

        // Full-scale value with busy window check
        issue(255);
        for (int k = 0; k < N; k++) begin
            check("busy_ready", ready, 0);
            tick();
        end
        check("done_ready", ready, 1);
        check("done_pulse", done, 1);
        tick();

        convert(0);
        convert(100);

        // Start during busy is ignored
        issue(7);
        tick();
        tick();
        start = 1'b1;
        bin   = N'(99);
        tick();
        start = 1'b0;
        wait_ready();
        tick();

        // Start held high: back-to-back conversions
        c = cyc;
        start = 1'b1;
        bin   = N'(42);
        for (int k = 1; k <= 3; k++) begin
            exp_t e;
            e.exp_bcd   = ref_bcd(42);
            e.exp_blank = ref_blank(42);
            e.exp_cyc   = c + k * (N + 1);
            q.push_back(e);
        end
        repeat (2 * (N + 1) + 1) tick();
        start = 1'b0;
        wait_ready();
        tick();

        // Reset mid-conversion aborts it
        issue(200);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
        check("abort_ready", ready, 1);
        check("abort_bcd", bcd, 0);
        check("abort_done", done, 0);
        convert(200);

        // Exhaustive sweep, back-to-back
        for (int v = 0; v < (1 << N); v++) convert(v);

        // Random values with random gaps
        repeat (40) begin
            repeat ($urandom_range(0, 3)) tick();
            convert(int'($urandom_range(0, (1 << N) - 1)));
        end

        n = 0;
        while (q.size() != 0 && n < 4 * N) begin
            tick();
            n++;
        end
        check("queue_drained", q.size(), 0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have parameter N, default 8: width of the binary input (matches the up/down counter value width).
REQ-002 The block SHALL have parameter D, default 3: number of BCD digits; the user must choose D with 10^D > 2^N-1.
REQ-003 The block SHALL have port sysclk  input  1: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1: reset, synchronous and active-high.
REQ-005 The block SHALL have port start  input  1: conversion request, sampled only while ready=1.
REQ-006 The block SHALL have port bin  input  N: binary value to convert, captured on the accepted start cycle.
REQ-007 The block SHALL have port ready  output  1: high when a start will be accepted.
REQ-008 The block SHALL have port done  output  1: one-cycle pulse marking a new result on bcd.
REQ-009 The block SHALL have port bcd  output  4*D: packed BCD result, digit i on bits [4i+3:4i], digit 0 least significant.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-011 IDLE: ready=1, done=0; start=1 SHALL capture bin, clear the working BCD register, load the iteration counter with N and go to SHIFT.
REQ-012 SHIFT: ready=0; each cycle SHALL add 3 to every working digit that is >=5, then shift {working BCD, binary shift register} left by 1 and decrement the iteration counter.
REQ-013 SHIFT SHALL last exactly N cycles, then go to DONE.
REQ-014 On entry to DONE, the working BCD value SHALL be copied to bcd and done SHALL be 1 for that single cycle.
REQ-015 DONE: ready=1; start=1 SHALL be accepted exactly as in IDLE (back-to-back, to SHIFT), otherwise the FSM SHALL go to IDLE.
REQ-016 Latency: start accepted at cycle t -> done=1 at cycle t+N+1; throughput one conversion per N+1 cycles.
REQ-017 start while ready=0 SHALL be ignored; bin changes after capture SHALL not affect the result.
REQ-018 bcd SHALL hold its last value between done pulses and change only in the done cycle.
REQ-019 Digit adjust arithmetic SHALL be 4-bit per digit; no carry out of digit D-1 occurs when the D constraint holds.
REQ-020 bin=0 SHALL produce bcd=0; bin=2^N-1 SHALL produce the exact decimal value (255 -> 0x255 for N=8, D=3).

Reset
REQ-021 While reset=1 at a clock edge: FSM SHALL go to IDLE, ready=1, done=0, bcd=0, working and shift registers cleared.
REQ-022 Reset during SHIFT or DONE SHALL abort the conversion with no done pulse; the next start after reset release SHALL be accepted.
REQ-023 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-024 Macro BIN2BCD_BLANK_EN defined: the block SHALL add output blank (D bits), registered and updated with bcd, bit i=1 when digit i and all higher digits are 0, for i>=1; bit 0 always 0; reset value 0.
REQ-025 Macro BIN2BCD_BLANK_EN undefined: the block SHALL omit the blank port and logic; all other behaviour is identical.

Verification
REQ-026 Reset, then N=8: start=1 with bin=255 at cycle t -> ready=0 cycles t+1..t+8, done=1 at t+9, bcd=0x255.
REQ-027 bin=0, start -> done at t+9, bcd=0x000; with BIN2BCD_BLANK_EN blank=3'b110; bin=100 -> bcd=0x100, blank=3'b000.
REQ-028 start=1 with bin=7 at t, start=1 with bin=99 at t+3 -> the second start is ignored, single done at t+9, bcd=0x007.
REQ-029 start held high continuously from t with bin=42 -> done at t+9, t+18, ..., each with bcd=0x042, no idle cycle between conversions.
REQ-030 reset=1 at t+4 of a conversion of 200 -> no done pulse, bcd=0x000, ready=1 after reset; new start of 200 -> bcd=0x200 nine cycles later.
REQ-031 Exhaustive sweep bin=0..255 against a decimal reference model -> all bcd results match.
